program_loader: RTL and testbench

- Loads a MIPS program image into instruction memory from a byte stream before execution starts.
- Sits between an external byte source (host UART/test stimulus) and the computer's imem write port.
- Holds the CPU in reset while loading and releases it when the image is complete.
- It is the supply end of the program interface whose results the computer bench checks via memwrite/dataadr/writedata.

---
 rtl/program_loader_pkg.sv | 26 ++
 rtl/program_loader_byte_assembler.sv | 48 ++++
 rtl/program_loader.sv | 144 ++++++++++++++
 tb/tb_program_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader_pkg
//  Purpose  : Shared types and constants for the program loader.
//             state_t        - loader FSM states
//             BYTES_PER_WORD - stream bytes per instruction word
//             LEN_W          - width of the stream length header
//  Revision : 1.0 - initial release
// ============================================================================
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    BYTES  = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 16;

endpackage
`default_nettype wire

// File: rtl/program_loader_byte_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader_byte_assembler
//  Purpose  : Collects stream bytes MSB-first into one instruction word.
//  Ports    : clk      - system clock
//             reset    - asynchronous active-low reset
//             shift_i  - accept byte_i this cycle
//             clear_i  - restart the byte count (word data is kept)
//             byte_i   - incoming stream byte
//             word_o   - assembled word (registered)
//             last_o   - full flag lookahead: the next accepted byte
//                        completes the word
//  Revision : 1.0 - initial release
// ============================================================================
module program_loader_byte_assembler
  import program_loader_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         shift_i,
  input  logic         clear_i,
  input  logic [7:0]   byte_i,
  output logic [n-1:0] word_o,
  output logic         last_o
);

  logic [n-1:0] word_q;
  logic [1:0]   cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      cnt_q  <= '0;
    end else if (shift_i) begin
      word_q <= {word_q[n-9:0], byte_i};
      cnt_q  <= cnt_q + 2'd1;
    end
  end

  assign word_o = word_q;
  assign last_o = (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader
//  Purpose  : Loads a program image from a byte stream into instruction
//             memory, holding the CPU in reset until the image is complete.
//             Stream: 16-bit big-endian word count, then the words MSB first.
//  Ports    : clk, reset (async, active-low)
//             start              - pulse to begin / restart a load
//             in_valid, in_data  - byte source
//             in_ready           - byte accepted when in_valid & in_ready
//             imem_we/addr/wdata - instruction memory write port
//             cpu_reset          - held high except when DONE
//             done, error        - load complete / length over capacity
//  Revision : 1.0 - initial release
// ============================================================================
module program_loader
  import program_loader_pkg::*;
#(
  parameter int n      = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [n-1:0]      imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam logic [LEN_W-1:0] CAPACITY = LEN_W'(2 ** ADDR_W);

  state_t              state_q, state_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    len_new;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic                in_ready_q, imem_we_q, cpu_reset_q, done_q, error_q;
  logic                xfer, asm_shift, asm_clear, asm_last;
  logic [n-1:0]        asm_word;

  assign xfer      = in_valid && in_ready_q;
  assign asm_shift = xfer && (state_q == BYTES);
  assign len_new   = {len_hi_q, in_data};

  program_loader_byte_assembler #(.n(n)) u_asm (
    .clk     (clk),
    .reset   (reset),
    .shift_i (asm_shift),
    .clear_i (asm_clear),
    .byte_i  (in_data),
    .word_o  (asm_word),
    .last_o  (asm_last)
  );

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    asm_clear  = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = LEN_HI;
          word_idx_d = '0;
          asm_clear  = 1'b1;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          len_hi_d = in_data;
          state_d  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_d      = len_new;
          word_idx_d = '0;
          asm_clear  = 1'b1;
          if (len_new == '0)           state_d = DONE;
          else if (len_new > CAPACITY) state_d = ERR;
          else                         state_d = BYTES;
        end
      end
      BYTES: begin
        if (xfer && asm_last) state_d = WRITE;
      end
      WRITE: begin
        asm_clear = 1'b1;
        // The final word leaves the address parked on the last location
        // rather than wrapping back to zero when the image fills imem.
        if (LEN_W'(word_idx_q) == len_q - LEN_W'(1)) begin
          state_d = DONE;
        end else begin
          word_idx_d = word_idx_q + ADDR_W'(1);
          state_d    = BYTES;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      len_hi_q    <= '0;
      len_q       <= '0;
      word_idx_q  <= '0;
      in_ready_q  <= 1'b0;
      imem_we_q   <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      // Outputs are decoded from the next state so they are registered
      // yet line up with the state they describe.
      in_ready_q  <= (state_d == LEN_HI) || (state_d == LEN_LO) || (state_d == BYTES);
      imem_we_q   <= (state_d == WRITE);
      cpu_reset_q <= (state_d != DONE);
      done_q      <= (state_d == DONE);
      error_q     <= (state_d == ERR);
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = word_idx_q;
  assign imem_wdata = asm_word;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_program_loader
//  Purpose  : Self-checking bench for program_loader.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int tests = 0;
  int fails = 0;

  program_loader #(.n(32), .ADDR_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Every imem write pulse is logged as {addr, data}.
  logic [37:0] wq[$];
  always @(negedge clk) begin
    if (reset === 1'b1 && imem_we === 1'b1) wq.push_back({imem_addr, imem_wdata});
  end

  typedef struct {
    logic        st;
    logic        vld;
    logic [7:0]  dat;
    logic        rdy;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        cpurst;
    logic        dn;
  } vec_t;

  vec_t       vecs[13];
  logic [7:0] stream[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, ".in_ready"},   32'(in_ready),  32'd0);
    chk({tag, ".imem_we"},    32'(imem_we),   32'd0);
    chk({tag, ".imem_addr"},  32'(imem_addr), 32'd0);
    chk({tag, ".imem_wdata"}, imem_wdata,     32'd0);
    chk({tag, ".cpu_reset"},  32'(cpu_reset), 32'd1);
    chk({tag, ".done"},       32'(done),      32'd0);
    chk({tag, ".error"},      32'(error),     32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Presents one byte after 'gap' idle cycles and holds it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 100; i++) begin
      if (in_ready === 1'b1) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_byte: byte %h never accepted, in_ready %b expected 1", b, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input int gap, input int nbytes);
    for (int i = 0; i < nbytes; i++) send_byte(stream[i], gap);
  endtask

  task automatic wait_done(input string tag);
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (done === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s.wait_done: done %b expected 1 within bound", tag, done);
    end
  endtask

  task automatic chk_write(input string tag, input int idx, input logic [5:0] a, input logic [31:0] d);
    if (idx < wq.size()) begin
      chk({tag, ".addr"}, 32'(wq[idx][37:32]), 32'(a));
      chk({tag, ".data"}, wq[idx][31:0], d);
    end else begin
      tests++;
      fails++;
      $display("FAIL %s: write %0d missing, got %0d writes expected more", tag, idx, wq.size());
    end
  endtask

  task automatic chk_two_words(input string tag);
    chk({tag, ".nwrites"}, 32'(wq.size()), 32'd2);
    chk_write({tag, ".w0"}, 0, 6'd0, 32'h2008_0005);
    chk_write({tag, ".w1"}, 1, 6'd1, 32'hAC08_0054);
    chk({tag, ".done"},      32'(done),      32'd1);
    chk({tag, ".cpu_reset"}, 32'(cpu_reset), 32'd0);
  endtask

  initial begin
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h54};
    //               st  vld dat     rdy we addr  wdata           cpu dn
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 6'd0, 32'h0,          1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 6'd0, 32'h0,          1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 6'd0, 32'h0,          1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'h20, 1'b1, 1'b0, 6'd0, 32'h0,          1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'h08, 1'b1, 1'b0, 6'd0, 32'h0,          1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 6'd0, 32'h0,          1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 6'd0, 32'h2008_0005,  1'b1, 1'b0};
    // Byte held during WRITE must not be consumed.
    vecs[7]  = '{1'b0, 1'b1, 8'hAC, 1'b1, 1'b0, 6'd1, 32'h0,          1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'hAC, 1'b1, 1'b0, 6'd1, 32'h0,          1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'h08, 1'b1, 1'b0, 6'd1, 32'h0,          1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 6'd1, 32'h0,          1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 8'h54, 1'b0, 1'b1, 6'd1, 32'hAC08_0054,  1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'd1, 32'h0,          1'b0, 1'b1};

    // Reset held with a valid byte on the bus.
    reset = 1'b0; start = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
    repeat (3) @(negedge clk);
    chk_idle_reset("reset");
    in_valid = 1'b0;
    reset    = 1'b1;

    // Back-to-back stream, cycle by cycle.
    wq.delete();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      start = vecs[i].st; in_valid = vecs[i].vld; in_data = vecs[i].dat;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.in_ready", i),  32'(in_ready),  32'(vecs[i].rdy));
      chk($sformatf("vec%0d.imem_we", i),   32'(imem_we),   32'(vecs[i].we));
      chk($sformatf("vec%0d.imem_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
      chk($sformatf("vec%0d.cpu_reset", i), 32'(cpu_reset), 32'(vecs[i].cpurst));
      chk($sformatf("vec%0d.done", i),      32'(done),      32'(vecs[i].dn));
      chk($sformatf("vec%0d.error", i),     32'(error),     32'd0);
      if (vecs[i].we) chk($sformatf("vec%0d.imem_wdata", i), imem_wdata, vecs[i].wdata);
    end
    @(negedge clk);
    in_valid = 1'b0; start = 1'b0;
    chk("table.nwrites", 32'(wq.size()), 32'd2);

    // Restart from DONE, then the same stream with 3-cycle stalls.
    wq.delete();
    pulse_start();
    chk("restart.done",      32'(done),      32'd0);
    chk("restart.cpu_reset", 32'(cpu_reset), 32'd1);
    chk("restart.in_ready",  32'(in_ready),  32'd1);
    send_stream(3, 10);
    wait_done("stall");
    chk_two_words("stall");

    // Oversized header.
    wq.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h41, 0);
    repeat (3) @(negedge clk);
    chk("err.error",     32'(error),       32'd1);
    chk("err.cpu_reset", 32'(cpu_reset),   32'd1);
    chk("err.in_ready",  32'(in_ready),    32'd0);
    chk("err.done",      32'(done),        32'd0);
    chk("err.nwrites",   32'(wq.size()),   32'd0);

    // Zero-length image goes straight to DONE.
    pulse_start();
    chk("err_restart.error", 32'(error), 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("len0.done",      32'(done),      32'd1);
    chk("len0.cpu_reset", 32'(cpu_reset), 32'd0);
    chk("len0.nwrites",   32'(wq.size()), 32'd0);

    // Single-word image after a zero-length load.
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'h56, 0); send_byte(8'h78, 0);
    wait_done("len1");
    chk("len1.nwrites", 32'(wq.size()), 32'd1);
    chk_write("len1.w0", 0, 6'd0, 32'h1234_5678);

    // Full-capacity image: 64 words, last write at address 63.
    wq.delete();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h40, 0);
    for (int w = 0; w < 64; w++) begin
      send_byte(8'(w), 0); send_byte(8'hA5, 0);
      send_byte(~8'(w), 0); send_byte(8'h3C, 0);
    end
    wait_done("len64");
    chk("len64.nwrites", 32'(wq.size()), 32'd64);
    for (int w = 0; w < 64; w++)
      chk_write($sformatf("len64.w%0d", w), w, 6'(w), {8'(w), 8'hA5, ~8'(w), 8'h3C});
    chk("len64.addr_park", 32'(imem_addr), 32'd63);

    // Reset in the middle of the second word, then a clean reload.
    wq.delete();
    pulse_start();
    send_stream(0, 8);
    #2 reset = 1'b0;
    #1;
    chk_idle_reset("midreset");
    @(negedge clk);
    reset = 1'b1;
    wq.delete();
    pulse_start();
    send_stream(0, 10);
    wait_done("reload");
    chk_two_words("reload");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
